// File: rtl/jtag_tap_ctrl.sv
// TAP controller: oversamples TCK/TMS/TDI in the ICLK domain, runs the 16-state
// 1149.1 FSM and issues one-ICLK scan-chain strobes plus the TDO mux.
module jtag_tap_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       ICLK,
   input  logic       RST,
   input  logic       tck,
   input  logic       tms,
   input  logic       tdi,
   input  logic       ir_tdo,
   input  logic       dr_tdo,
   output logic       s_data,
   output logic       shift_ir,
   output logic       clk_ir,
   output logic       update_ir,
   output logic       shift_dr,
   output logic       clk_dr,
   output logic       update_dr,
   output logic       tdo,
   output logic       tdo_en,
   output logic       tlr,
   output logic [3:0] tap_state
);

   // state | meaning
   // TLR   | test-logic-reset
   // RTI   | run-test/idle
   // SELx  | select DR/IR scan
   // CAPx  | capture (parallel load on next rise)
   // SHx   | shift
   // EX1x  | exit1
   // PAx   | pause
   // EX2x  | exit2
   // UPx   | update (strobe on TCK fall)
   typedef enum logic [3:0] {
      TLR   = 4'd0,  RTI   = 4'd1,  SELDR = 4'd2,  CAPDR = 4'd3,
      SHDR  = 4'd4,  EX1DR = 4'd5,  PADR  = 4'd6,  EX2DR = 4'd7,
      UPDR  = 4'd8,  SELIR = 4'd9,  CAPIR = 4'd10, SHIR  = 4'd11,
      EX1IR = 4'd12, PAIR  = 4'd13, EX2IR = 4'd14, UPIR  = 4'd15
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
   logic tck_prev;
   logic rise, fall, tms_s, tdi_s;

   logic s_data_d, shift_ir_d, clk_ir_d, update_ir_d;
   logic shift_dr_d, clk_dr_d, update_dr_d, tdo_d, tdo_en_d;

   always_ff @(posedge ICLK or posedge RST) begin
      if (RST) begin
         tck_sync <= '0;
         tms_sync <= '0;
         tdi_sync <= '0;
         tck_prev <= 1'b0;
      end else begin
         tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
         tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
         tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
         tck_prev <= tck_sync[SYNC_STAGES-1];
      end
   end

   assign rise  = tck_sync[SYNC_STAGES-1] & ~tck_prev;
   assign fall  = ~tck_sync[SYNC_STAGES-1] & tck_prev;
   assign tms_s = tms_sync[SYNC_STAGES-1];
   assign tdi_s = tdi_sync[SYNC_STAGES-1];

   always_ff @(posedge ICLK or posedge RST) begin
      if (RST) begin
         state     <= TLR;
         s_data    <= 1'b0;
         shift_ir  <= 1'b0;
         clk_ir    <= 1'b0;
         update_ir <= 1'b0;
         shift_dr  <= 1'b0;
         clk_dr    <= 1'b0;
         update_dr <= 1'b0;
         tdo       <= 1'b0;
         tdo_en    <= 1'b0;
      end else begin
         state     <= state_nxt;
         s_data    <= s_data_d;
         shift_ir  <= shift_ir_d;
         clk_ir    <= clk_ir_d;
         update_ir <= update_ir_d;
         shift_dr  <= shift_dr_d;
         clk_dr    <= clk_dr_d;
         update_dr <= update_dr_d;
         tdo       <= tdo_d;
         tdo_en    <= tdo_en_d;
      end
   end

   always_comb begin
      state_nxt = state;
      if (rise) begin
         unique case (state)
            TLR:   state_nxt = tms_s ? TLR   : RTI;
            RTI:   state_nxt = tms_s ? SELDR : RTI;
            SELDR: state_nxt = tms_s ? SELIR : CAPDR;
            CAPDR: state_nxt = tms_s ? EX1DR : SHDR;
            SHDR:  state_nxt = tms_s ? EX1DR : SHDR;
            EX1DR: state_nxt = tms_s ? UPDR  : PADR;
            PADR:  state_nxt = tms_s ? EX2DR : PADR;
            EX2DR: state_nxt = tms_s ? UPDR  : SHDR;
            UPDR:  state_nxt = tms_s ? SELDR : RTI;
            SELIR: state_nxt = tms_s ? TLR   : CAPIR;
            CAPIR: state_nxt = tms_s ? EX1IR : SHIR;
            SHIR:  state_nxt = tms_s ? EX1IR : SHIR;
            EX1IR: state_nxt = tms_s ? UPIR  : PAIR;
            PAIR:  state_nxt = tms_s ? EX2IR : PAIR;
            EX2IR: state_nxt = tms_s ? UPIR  : SHIR;
            UPIR:  state_nxt = tms_s ? SELDR : RTI;
            default: state_nxt = TLR;
         endcase
      end
   end

   // Rise and fall are mutually exclusive, so clk_* and update_* never coincide.
   always_comb begin
      s_data_d    = s_data;
      shift_ir_d  = shift_ir;
      shift_dr_d  = shift_dr;
      tdo_d       = tdo;
      tdo_en_d    = tdo_en;
      clk_ir_d    = rise && (state == CAPIR || state == SHIR);
      clk_dr_d    = rise && (state == CAPDR || state == SHDR);
      update_ir_d = fall && (state == UPIR);
      update_dr_d = fall && (state == UPDR);
      if (rise) begin
         s_data_d   = tdi_s;
         shift_ir_d = (state == SHIR);
         shift_dr_d = (state == SHDR);
      end
      if (fall) begin
         tdo_en_d = (state == SHIR) || (state == SHDR);
         tdo_d    = (state == SHIR) ? ir_tdo :
                    (state == SHDR) ? dr_tdo : 1'b0;
      end
   end

   assign tlr       = (state == TLR);
   assign tap_state = state;

endmodule
